// File: rtl/vram_fetch.sv
// Text-mode VRAM fetch sequencer: a char+attr read per display cell, host reads in idle slots.
// Optional host read path is compiled in when VRAM_FETCH_HOSTRD_EN is defined.
module vram_fetch #(
    parameter int          COLS      = 80,
    parameter int          CHAR_H    = 16,
    parameter logic [12:0] ATTR_BASE = 13'd4096
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        frameStart,
    input  logic        lineEnd,
    input  logic        cellFetch,
    output logic [7:0]  cellChar,
    output logic [7:0]  cellAttr,
    output logic        cellValid,
    output logic        fetchOverrun,
    input  logic        hostRdReq,
    input  logic [12:0] hostRdAddr,
    output logic [7:0]  hostRdData,
    output logic        hostRdAck,
    output logic [12:0] vramRdAddr,
    input  logic [7:0]  vramRdData
);

    localparam int                SCAN_W    = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(CHAR_H - 1);
    localparam logic [12:0]       ROW_STEP  = 13'(COLS);

`ifdef VRAM_FETCH_HOSTRD_EN
    typedef enum logic [2:0] {IDLE, FCHAR, FATTR, FDONE, HADDR, HDATA} state_t;
`else
    typedef enum logic [2:0] {IDLE, FCHAR, FATTR, FDONE} state_t;
`endif

    state_t             state_q, state_d;
    logic               pend_q, pend_d;
    logic               ovr_q, ovr_d;
    logic [12:0]        col_q, col_d;
    logic [SCAN_W-1:0]  scan_q, scan_d;
    logic [12:0]        row_q, row_d;
    logic [12:0]        vaddr_q, vaddr_d;
    logic [12:0]        attr_addr_q, attr_addr_d;
    logic [7:0]         char_tmp_q, char_tmp_d;
    logic [7:0]         cell_char_q, cell_char_d;
    logic [7:0]         cell_attr_q, cell_attr_d;
    logic               cell_valid_q, cell_valid_d;
    logic [7:0]         host_data_q, host_data_d;
    logic               host_ack_q, host_ack_d;
    logic               accept;
    logic [12:0]        fetch_char;
    logic [12:0]        fetch_attr;

    // Address sums wrap naturally in 13 bits.
    assign fetch_char = row_q + col_q;
    assign fetch_attr = ATTR_BASE + fetch_char;

`ifndef VRAM_FETCH_HOSTRD_EN
    logic unused_host;
    assign unused_host = ^{hostRdReq, hostRdAddr};
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            pend_q       <= 1'b0;
            ovr_q        <= 1'b0;
            col_q        <= '0;
            scan_q       <= '0;
            row_q        <= '0;
            vaddr_q      <= '0;
            attr_addr_q  <= '0;
            char_tmp_q   <= '0;
            cell_char_q  <= '0;
            cell_attr_q  <= '0;
            cell_valid_q <= 1'b0;
            host_data_q  <= '0;
            host_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            ovr_q        <= ovr_d;
            col_q        <= col_d;
            scan_q       <= scan_d;
            row_q        <= row_d;
            vaddr_q      <= vaddr_d;
            attr_addr_q  <= attr_addr_d;
            char_tmp_q   <= char_tmp_d;
            cell_char_q  <= cell_char_d;
            cell_attr_q  <= cell_attr_d;
            cell_valid_q <= cell_valid_d;
            host_data_q  <= host_data_d;
            host_ack_q   <= host_ack_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        vaddr_d      = vaddr_q;
        attr_addr_d  = attr_addr_q;
        char_tmp_d   = char_tmp_q;
        cell_char_d  = cell_char_q;
        cell_attr_d  = cell_attr_q;
        cell_valid_d = 1'b0;
        host_data_d  = host_data_q;
        host_ack_d   = 1'b0;
        accept       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q || cellFetch) begin
                    accept      = 1'b1;
                    state_d     = FCHAR;
                    vaddr_d     = fetch_char;
                    attr_addr_d = fetch_attr;
                end
`ifdef VRAM_FETCH_HOSTRD_EN
                // The host still holds its request during the ack cycle; don't re-serve it.
                else if (hostRdReq && !host_ack_q) begin
                    state_d = HADDR;
                    vaddr_d = hostRdAddr;
                end
`endif
            end
            FCHAR: begin
                state_d = FATTR;
                vaddr_d = attr_addr_q;
            end
            FATTR: begin
                // Character byte arrives one cycle after its address was presented.
                state_d    = FDONE;
                char_tmp_d = vramRdData;
            end
            FDONE: begin
                state_d      = IDLE;
                cell_char_d  = char_tmp_q;
                cell_attr_d  = vramRdData;
                cell_valid_d = 1'b1;
            end
`ifdef VRAM_FETCH_HOSTRD_EN
            HADDR: begin
                state_d = HDATA;
            end
            HDATA: begin
                state_d     = IDLE;
                host_data_d = vramRdData;
                host_ack_d  = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        col_d  = col_q;
        scan_d = scan_q;
        row_d  = row_q;
        pend_d = pend_q;
        ovr_d  = ovr_q;
        if (frameStart) begin
            col_d  = '0;
            scan_d = '0;
            row_d  = '0;
        end else if (lineEnd) begin
            col_d = '0;
            if (scan_q == SCAN_LAST) begin
                scan_d = '0;
                row_d  = row_q + ROW_STEP;
            end else begin
                scan_d = scan_q + SCAN_W'(1);
            end
        end else if (accept) begin
            col_d = col_q + 13'd1;
        end
        // A request arriving while the pending one is consumed becomes the new pending one.
        if (accept) begin
            pend_d = pend_q & cellFetch;
        end else if (cellFetch && (state_q != IDLE)) begin
            if (pend_q) begin
                ovr_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end
        if (frameStart) begin
            ovr_d = 1'b0;
        end
    end

    assign cellChar     = cell_char_q;
    assign cellAttr     = cell_attr_q;
    assign cellValid    = cell_valid_q;
    assign fetchOverrun = ovr_q;
    assign hostRdData   = host_data_q;
    assign hostRdAck    = host_ack_q;
    assign vramRdAddr   = vaddr_q;

endmodule

// File: tb/tb_vram_fetch.sv
// Self-checking bench for vram_fetch: directed scenarios plus random traffic against a
// cycle-stamped transaction model of fetches, host reads and the row/column counters.
module tb_vram_fetch;

    localparam int COLS   = 80;
    localparam int CHAR_H = 16;
    localparam int ATTR   = 4096;
    localparam int NCYC   = 8192;
`ifdef VRAM_FETCH_HOSTRD_EN
    localparam bit HOST_EN = 1'b1;
`else
    localparam bit HOST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nrst;
    logic        frameStart, lineEnd, cellFetch;
    logic [7:0]  cellChar, cellAttr;
    logic        cellValid, fetchOverrun;
    logic        hostRdReq;
    logic [12:0] hostRdAddr;
    logic [7:0]  hostRdData;
    logic        hostRdAck;
    logic [12:0] vramRdAddr;
    logic [7:0]  vramRdData;

    always #5 clk = ~clk;

    vram_fetch #(.COLS(COLS), .CHAR_H(CHAR_H), .ATTR_BASE(13'd4096)) dut (
        .clk(clk), .nrst(nrst), .frameStart(frameStart), .lineEnd(lineEnd),
        .cellFetch(cellFetch), .cellChar(cellChar), .cellAttr(cellAttr),
        .cellValid(cellValid), .fetchOverrun(fetchOverrun), .hostRdReq(hostRdReq),
        .hostRdAddr(hostRdAddr), .hostRdData(hostRdData), .hostRdAck(hostRdAck),
        .vramRdAddr(vramRdAddr), .vramRdData(vramRdData)
    );

    logic [7:0] mem [0:8191];
    always @(posedge clk) vramRdData <= mem[vramRdAddr];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = -1;

    // Reference model state
    int          m_row, m_scan, m_col, free_at;
    bit          m_pend, m_ovr;
    logic [12:0] m_addr;
    logic [7:0]  m_char, m_attr, m_hdata;
    bit          s_addr_v [NCYC];
    logic [12:0] s_addr   [NCYC];
    bit          s_valid  [NCYC];
    logic [7:0]  s_char   [NCYC];
    logic [7:0]  s_attr   [NCYC];
    bit          s_ack    [NCYC];
    logic [7:0]  s_hdata  [NCYC];

    // Observed DUT outputs per cycle
    logic [12:0] o_addr  [NCYC];
    logic        o_valid [NCYC];
    logic [7:0]  o_char  [NCYC];
    logic [7:0]  o_attr  [NCYC];
    logic        o_ack   [NCYC];
    logic [7:0]  o_hdata [NCYC];
    logic        o_ovr   [NCYC];

    // Host agent
    bit          h_auto = 1'b0;
    bit          h_drop = 1'b0;
    bit          h_start = 1'b0;
    logic [12:0] h_start_addr = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset(input int from);
        for (int i = (from < 0 ? 0 : from); i < NCYC; i++) begin
            s_addr_v[i] = 1'b0;
            s_valid[i]  = 1'b0;
            s_ack[i]    = 1'b0;
        end
        m_row = 0; m_scan = 0; m_col = 0; free_at = 0;
        m_pend = 1'b0; m_ovr = 1'b0;
        m_addr = '0; m_char = '0; m_attr = '0; m_hdata = '0;
    endtask

    task automatic begin_cyc();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc > NCYC - 10) begin
            $display("FAIL cycle_budget cyc=%0d got=%0d expected<%0d", cyc, cyc, NCYC - 10);
            $fatal(1, "cycle budget exceeded");
        end
        if (s_addr_v[cyc]) m_addr = s_addr[cyc];
        if (s_valid[cyc]) begin
            m_char = s_char[cyc];
            m_attr = s_attr[cyc];
        end
        if (s_ack[cyc]) m_hdata = s_hdata[cyc];
        o_addr[cyc] = vramRdAddr; o_valid[cyc] = cellValid; o_char[cyc] = cellChar;
        o_attr[cyc] = cellAttr;   o_ack[cyc] = hostRdAck;   o_hdata[cyc] = hostRdData;
        o_ovr[cyc]  = fetchOverrun;
        check_val("vramRdAddr", 32'(vramRdAddr), 32'(m_addr));
        check_val("cellValid", 32'(cellValid), 32'(s_valid[cyc]));
        check_val("cellChar", 32'(cellChar), 32'(m_char));
        check_val("cellAttr", 32'(cellAttr), 32'(m_attr));
        check_val("fetchOverrun", 32'(fetchOverrun), 32'(m_ovr));
        check_val("hostRdAck", 32'(hostRdAck), 32'(s_ack[cyc]));
        check_val("hostRdData", 32'(hostRdData), 32'(m_hdata));
    endtask

    task automatic end_cyc(input bit fs, input bit le, input bit cf);
        int ca, aa;
        bit acc;
        frameStart = fs; lineEnd = le; cellFetch = cf;
        if (h_drop) begin
            hostRdReq = 1'b0;
            h_drop = 1'b0;
        end else if (hostRdReq && s_ack[cyc]) begin
            h_drop = 1'b1;
        end else if (!hostRdReq && (h_start || (h_auto && $urandom_range(7) == 0))) begin
            hostRdReq  = 1'b1;
            hostRdAddr = h_start ? h_start_addr : 13'($urandom);
            h_start    = 1'b0;
        end
        acc = 1'b0;
        if (cyc >= free_at) begin
            if (m_pend || cf) begin
                ca = (m_row + m_col) % 8192;
                aa = (ATTR + m_row + m_col) % 8192;
                s_addr_v[cyc+1] = 1'b1; s_addr[cyc+1] = 13'(ca);
                s_addr_v[cyc+2] = 1'b1; s_addr[cyc+2] = 13'(aa);
                s_valid[cyc+4] = 1'b1; s_char[cyc+4] = mem[ca]; s_attr[cyc+4] = mem[aa];
                free_at = cyc + 4;
                acc = 1'b1;
                m_pend = m_pend && cf;
            end else if (HOST_EN && hostRdReq && !s_ack[cyc]) begin
                s_addr_v[cyc+1] = 1'b1; s_addr[cyc+1] = hostRdAddr;
                s_ack[cyc+3] = 1'b1; s_hdata[cyc+3] = mem[hostRdAddr];
                free_at = cyc + 3;
            end
        end else if (cf) begin
            if (m_pend) m_ovr = 1'b1;
            else m_pend = 1'b1;
        end
        if (fs) begin
            m_row = 0; m_scan = 0; m_col = 0; m_ovr = 1'b0;
        end else if (le) begin
            m_col = 0;
            if (m_scan == CHAR_H - 1) begin
                m_scan = 0;
                m_row = (m_row + COLS) % 8192;
            end else begin
                m_scan++;
            end
        end else if (acc) begin
            m_col = (m_col + 1) % 8192;
        end
    endtask

    task automatic tick(input bit fs, input bit le, input bit cf);
        begin_cyc();
        end_cyc(fs, le, cf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_zero_outputs(input string pfx);
        check_val({pfx, "_vramRdAddr"}, 32'(vramRdAddr), 32'd0);
        check_val({pfx, "_cellValid"}, 32'(cellValid), 32'd0);
        check_val({pfx, "_cellChar"}, 32'(cellChar), 32'd0);
        check_val({pfx, "_cellAttr"}, 32'(cellAttr), 32'd0);
        check_val({pfx, "_fetchOverrun"}, 32'(fetchOverrun), 32'd0);
        check_val({pfx, "_hostRdAck"}, 32'(hostRdAck), 32'd0);
        check_val({pfx, "_hostRdData"}, 32'(hostRdData), 32'd0);
    endtask

    task automatic do_reset_mid();
        #2 nrst = 1'b0;
        #1 check_zero_outputs("rst_mid");
        model_reset(cyc + 1);
        begin_cyc();
        nrst = 1'b1;
        end_cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_s1(input string pfx);
        int c0;
        tick(1'b1, 1'b0, 1'b0);
        c0 = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, 1'b1);
            idle(7);
        end
        check_val({pfx, "_addr_c0"}, 32'(o_addr[c0+1]), 32'd0);
        check_val({pfx, "_addr_a0"}, 32'(o_addr[c0+2]), 32'd4096);
        check_val({pfx, "_addr_c1"}, 32'(o_addr[c0+9]), 32'd1);
        check_val({pfx, "_addr_a1"}, 32'(o_addr[c0+10]), 32'd4097);
        check_val({pfx, "_addr_c2"}, 32'(o_addr[c0+17]), 32'd2);
        check_val({pfx, "_addr_a2"}, 32'(o_addr[c0+18]), 32'd4098);
        check_val({pfx, "_valid_lat4"}, 32'(o_valid[c0+4]), 32'd1);
        check_val({pfx, "_char0"}, 32'(o_char[c0+4]), 32'(mem[0]));
        check_val({pfx, "_attr0"}, 32'(o_attr[c0+4]), 32'(mem[4096]));
        check_val({pfx, "_valid2_lat4"}, 32'(o_valid[c0+20]), 32'd1);
        check_val({pfx, "_attr2"}, 32'(o_attr[c0+20]), 32'(mem[4098]));
    endtask

    initial begin
        int c;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        nrst = 1'b0; frameStart = 1'b0; lineEnd = 1'b0; cellFetch = 1'b0;
        hostRdReq = 1'b0; hostRdAddr = '0;
        model_reset(0);
        repeat (2) @(posedge clk);
        #1 check_zero_outputs("reset");
        #1 nrst = 1'b1;

        // Three spaced fetches from frame start
        run_s1("s1");

        // Row advance after CHAR_H line ends, none after CHAR_H-1
        tick(1'b1, 1'b0, 1'b0);
        repeat (16) tick(1'b0, 1'b1, 1'b0);
        c = cyc + 1;
        tick(1'b0, 1'b0, 1'b1);
        idle(5);
        check_val("row16_char", 32'(o_addr[c+1]), 32'd80);
        check_val("row16_attr", 32'(o_addr[c+2]), 32'd4176);
        tick(1'b1, 1'b0, 1'b0);
        repeat (15) tick(1'b0, 1'b1, 1'b0);
        c = cyc + 1;
        tick(1'b0, 1'b0, 1'b1);
        idle(5);
        check_val("row15_char", 32'(o_addr[c+1]), 32'd0);

        // Pending fetch and overrun
        tick(1'b1, 1'b0, 1'b0);
        c = cyc + 1;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        idle(8);
        check_val("pend_valid4", 32'(o_valid[c+4]), 32'd1);
        check_val("pend_valid8", 32'(o_valid[c+8]), 32'd1);
        check_val("pend_ovr_before", 32'(o_ovr[c+3]), 32'd0);
        check_val("ovr_set", 32'(o_ovr[c+4]), 32'd1);
        c = cyc + 1;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check_val("ovr_cleared", 32'(o_ovr[c+1]), 32'd0);

`ifdef VRAM_FETCH_HOSTRD_EN
        // Host read at the top address, then host racing a display fetch
        idle(2);
        h_start = 1'b1; h_start_addr = 13'h1FFF;
        c = cyc + 1;
        idle(6);
        check_val("host_addr", 32'(o_addr[c+1]), 32'h1FFF);
        check_val("host_ack3", 32'(o_ack[c+3]), 32'd1);
        check_val("host_data", 32'(o_hdata[c+3]), 32'(mem[13'h1FFF]));
        idle(2);
        h_start = 1'b1; h_start_addr = 13'h0123;
        c = cyc + 1;
        tick(1'b0, 1'b0, 1'b1);
        idle(9);
        check_val("race_valid4", 32'(o_valid[c+4]), 32'd1);
        check_val("race_ack7", 32'(o_ack[c+7]), 32'd1);
        check_val("race_hdata", 32'(o_hdata[c+7]), 32'(mem[13'h0123]));
`endif

        // Address wrap at rowBase 8160, then reset during FATTR
        tick(1'b1, 1'b0, 1'b0);
        repeat (102 * CHAR_H) tick(1'b0, 1'b1, 1'b0);
        repeat (40) begin
            tick(1'b0, 1'b0, 1'b1);
            idle(3);
        end
        c = cyc + 1;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check_val("wrap_char", 32'(o_addr[c+1]), 32'd8);
        check_val("wrap_attr", 32'(o_addr[c+2]), 32'd4104);
        do_reset_mid();
        idle(4);
        check_val("abort_no_valid", 32'(o_valid[c+4]), 32'd0);

`ifndef VRAM_FETCH_HOSTRD_EN
        // Host request held high is ignored; display timing is unchanged
        hostRdReq = 1'b1; hostRdAddr = 13'h0ABC;
        run_s1("nohost");
`endif

        // Random traffic
        h_auto = 1'b1;
        repeat (3000)
            tick($urandom_range(499) == 0, $urandom_range(39) == 0, $urandom_range(4) == 0);
        h_auto = 1'b0;
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
